// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache address split and frame layout.
package cpu_types_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned ICACHE_SETS  = 16;
  localparam int unsigned ICACHE_IDX_W = 4;
  localparam int unsigned ICACHE_BYT_W = 2;
  localparam int unsigned ICACHE_TAG_W = WORD_W - ICACHE_IDX_W - ICACHE_BYT_W;

  typedef logic [WORD_W-1:0] word_t;

  // Fetch address split for the default cache geometry
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [ICACHE_BYT_W-1:0] bytoff;
  } icachef_t;

  // One direct-mapped frame for the default cache geometry
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hits, one-word line fills on miss.
module icache
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state_q, state_d;
  logic [29:0]        miss_addr_q, miss_addr_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [SETS];
  word_t              data_q [SETS];

  logic               fill_en;
  logic               hit;
  logic [IDX_W-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               unused_offset;

  assign req_idx       = imemaddr[IDX_W+1:2];
  assign req_tag       = imemaddr[31:IDX_W+2];
  assign fill_idx      = miss_addr_q[IDX_W-1:0];
  assign fill_tag      = miss_addr_q[29:IDX_W];
  assign unused_offset = ^imemaddr[1:0];
  assign hit           = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Control state, pending miss address and valid bits; all cleared by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data storage are not reset; only valid bits gate their use
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

  // Next-state, fill strobe and datapath/memory-side outputs
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;
    fill_en     = 1'b0;
    ihit        = 1'b0;
    iREN        = 1'b0;
    imemload    = data_q[req_idx];
    iaddr       = {miss_addr_q, 2'b00};
    case (state_q)
      IDLE: begin
        ihit = hit;
        if (imemREN && !hit) begin
          miss_addr_d = imemaddr[31:2];
          state_d     = FETCH;
        end
      end
      FETCH: begin
        iREN = 1'b1;
        if (!iwait) begin
          fill_en           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
